// File: rtl/pipeline_debug_ctrl.sv
// Debug sequencer between the UART wrappers and the MIPS pipeline: runs or single-steps
// the pipeline and streams a frozen snapshot of the register bank out bytewise.
module pipeline_debug_ctrl #(
  parameter int         REGISTER_BANK_SIZE = 32,
  parameter int         BUS_SIZE           = 32,
  parameter logic [7:0] CMD_RUN            = 8'h52,
  parameter logic [7:0] CMD_STEP           = 8'h53,
  parameter logic [7:0] CMD_DUMP           = 8'h44
) (
  input  logic                                   i_clk,
  input  logic                                   i_reset,
  input  logic [7:0]                             i_cmd,
  input  logic                                   i_cmd_valid,
  output logic                                   o_cmd_ready,
  input  logic                                   i_halt,
  input  logic [REGISTER_BANK_SIZE*BUS_SIZE-1:0] i_reg_bank_debug,
  output logic                                   o_pipeline_enable,
  output logic [7:0]                             o_tx_data,
  output logic                                   o_tx_valid,
  input  logic                                   i_tx_ready,
  output logic                                   o_busy
);

  localparam int BANK_W = REGISTER_BANK_SIZE * BUS_SIZE;
  localparam int BPR    = BUS_SIZE / 8;
  localparam int NBYTES = REGISTER_BANK_SIZE * BPR;
  localparam int CNT_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NBYTES - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_STEP, S_DUMP} state_t;

  state_t             state_q, state_d;
  logic               enable_q, enable_d;
  logic               tx_valid_q, tx_valid_d;
  logic [7:0]         tx_data_q, tx_data_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [BANK_W-1:0]  snap_q, snap_d;
  logic               cmd_ready;

  // Byte idx of the stream: registers in ascending order, MSB first within each register.
  function automatic logic [7:0] pick_byte(input logic [BANK_W-1:0] v,
                                           input logic [CNT_W-1:0]  idx);
    int unsigned r;
    int unsigned b;
    int unsigned off;
    logic [BANK_W-1:0] s;
    r   = int'(idx) / BPR;
    b   = int'(idx) % BPR;
    off = r * BUS_SIZE + BUS_SIZE - 8 - 8 * b;
    s   = v >> off;
    return s[7:0];
  endfunction

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      enable_q   <= 1'b0;
      tx_valid_q <= 1'b0;
      tx_data_q  <= 8'h00;
      cnt_q      <= '0;
      snap_q     <= '0;
    end else begin
      enable_q   <= enable_d;
      tx_valid_q <= tx_valid_d;
      tx_data_q  <= tx_data_d;
      cnt_q      <= cnt_d;
      snap_q     <= snap_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    enable_d   = 1'b0;
    tx_valid_d = tx_valid_q;
    tx_data_d  = tx_data_q;
    cnt_d      = cnt_q;
    snap_d     = snap_q;
    unique case (state_q)
      S_IDLE: begin
        if (i_cmd_valid && cmd_ready) begin
          // Halt is judged in the acceptance cycle; a halted pipeline swallows RUN/STEP.
          if (i_cmd == CMD_RUN) begin
            if (!i_halt) begin
              state_d  = S_RUN;
              enable_d = 1'b1;
            end
          end else if (i_cmd == CMD_STEP) begin
            if (!i_halt) begin
              state_d  = S_STEP;
              enable_d = 1'b1;
            end
          end else if (i_cmd == CMD_DUMP) begin
            state_d    = S_DUMP;
            snap_d     = i_reg_bank_debug;
            cnt_d      = '0;
            tx_valid_d = 1'b1;
            tx_data_d  = pick_byte(i_reg_bank_debug, '0);
          end
        end
      end
      S_RUN: begin
        if (i_halt) state_d = S_IDLE;
        else        enable_d = 1'b1;
      end
      S_STEP: state_d = S_IDLE;
      S_DUMP: begin
        if (tx_valid_q && i_tx_ready) begin
          if (cnt_q == LAST_IDX) begin
            tx_valid_d = 1'b0;
            state_d    = S_IDLE;
          end else begin
            cnt_d     = cnt_q + 1'b1;
            tx_data_d = pick_byte(snap_q, cnt_q + 1'b1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    cmd_ready = (state_q == S_IDLE) && i_reset;
    o_busy    = (state_q != S_IDLE);
  end

  assign o_cmd_ready       = cmd_ready;
  assign o_pipeline_enable = enable_q;
  assign o_tx_valid        = tx_valid_q;
  assign o_tx_data         = tx_data_q;

endmodule

// File: tb/tb_pipeline_debug_ctrl.sv
// Scoreboard bench for pipeline_debug_ctrl: directed run/step/dump sequences with a
// byte queue checked by an independent TX monitor.
module tb_pipeline_debug_ctrl;

  localparam int NREG = 32;
  localparam logic [7:0] C_RUN  = 8'h52;
  localparam logic [7:0] C_STEP = 8'h53;
  localparam logic [7:0] C_DUMP = 8'h44;

  logic          i_clk = 1'b0;
  logic          i_reset;
  logic [7:0]    i_cmd;
  logic          i_cmd_valid;
  logic          o_cmd_ready;
  logic          i_halt;
  logic [NREG*32-1:0] i_reg_bank_debug;
  logic          o_pipeline_enable;
  logic [7:0]    o_tx_data;
  logic          o_tx_valid;
  logic          i_tx_ready;
  logic          o_busy;

  pipeline_debug_ctrl dut (
    .i_clk             (i_clk),
    .i_reset           (i_reset),
    .i_cmd             (i_cmd),
    .i_cmd_valid       (i_cmd_valid),
    .o_cmd_ready       (o_cmd_ready),
    .i_halt            (i_halt),
    .i_reg_bank_debug  (i_reg_bank_debug),
    .o_pipeline_enable (o_pipeline_enable),
    .o_tx_data         (o_tx_data),
    .o_tx_valid        (o_tx_valid),
    .i_tx_ready        (i_tx_ready),
    .o_busy            (o_busy)
  );

  always #5 i_clk = ~i_clk;

  int n_checks = 0;
  int n_fail   = 0;
  int n_pop    = 0;
  logic [7:0] exp_q[$];
  logic       stall_prev = 1'b0;
  logic [7:0] held = 8'h00;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected stream of one register: most significant byte first.
  task automatic push_reg(input logic [31:0] v);
    for (int b = 3; b >= 0; b--) exp_q.push_back(v[8*b +: 8]);
  endtask

  task automatic push_bank(input logic [NREG*32-1:0] bank);
    for (int k = 0; k < NREG; k++) push_reg(bank[k*32 +: 32]);
  endtask

  task automatic send_cmd(input logic [7:0] c);
    bit ok;
    ok = 1'b0;
    i_cmd       = c;
    i_cmd_valid = 1'b1;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge i_clk);
      if (o_cmd_ready) ok = 1'b1;
    end
    @(posedge i_clk);
    #1;
    i_cmd_valid = 1'b0;
    check("cmd_accept", 32'(ok), 32'd1);
  endtask

  // TX monitor: pops the scoreboard on every transfer, checks data holds during stalls.
  always @(negedge i_clk) begin
    logic [7:0] e;
    if (!i_reset) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev && o_tx_valid) check("stall_hold", 32'(o_tx_data), 32'(held));
      if (o_tx_valid && i_tx_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_byte", 32'(o_tx_data), 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          check("tx_byte", 32'(o_tx_data), 32'(e));
          n_pop++;
        end
      end
      stall_prev = o_tx_valid && !i_tx_ready;
      held       = o_tx_data;
    end
  end

  initial begin
    logic [NREG*32-1:0] bank1, bank2;
    int en_cnt, busy_cnt, vcnt, base;
    bit done;

    i_reset = 1'b0; i_cmd = 8'h00; i_cmd_valid = 1'b0; i_halt = 1'b0;
    i_tx_ready = 1'b0; i_reg_bank_debug = '0;
    for (int k = 0; k < NREG; k++) begin
      bank1[k*32 +: 32] = 32'hA0A0_0000 + 32'(k);
      bank2[k*32 +: 32] = 32'h1357_9BDF ^ (32'(k) * 32'h0101_0101);
    end

    // Reset
    repeat (3) @(posedge i_clk);
    #1;
    check("rst_enable", 32'(o_pipeline_enable), 32'd0);
    check("rst_tx_valid", 32'(o_tx_valid), 32'd0);
    check("rst_tx_data", 32'(o_tx_data), 32'd0);
    check("rst_busy", 32'(o_busy), 32'd0);
    check("rst_ready_held", 32'(o_cmd_ready), 32'd0);
    i_reset = 1'b1;
    @(negedge i_clk);
    check("post_rst_ready", 32'(o_cmd_ready), 32'd1);
    check("post_rst_busy", 32'(o_busy), 32'd0);
    check("post_rst_enable", 32'(o_pipeline_enable), 32'd0);
    @(posedge i_clk); #1;

    // Single step
    send_cmd(C_STEP);
    en_cnt = 0; busy_cnt = 0;
    repeat (5) begin
      @(negedge i_clk);
      en_cnt += int'(o_pipeline_enable);
      busy_cnt += int'(o_busy);
    end
    check("step_enable_cycles", 32'(en_cnt), 32'd1);
    check("step_busy_cycles", 32'(busy_cnt), 32'd1);
    @(posedge i_clk); #1;

    // Unknown command is swallowed
    send_cmd(8'h00);
    @(negedge i_clk);
    check("unknown_busy", 32'(o_busy), 32'd0);
    check("unknown_enable", 32'(o_pipeline_enable), 32'd0);
    @(posedge i_clk); #1;

    // Run until halt after 10 enabled cycles
    send_cmd(C_RUN);
    en_cnt = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge i_clk);
      if (o_pipeline_enable) en_cnt++;
      if (i == 2) check("run_ready_low", 32'(o_cmd_ready), 32'd0);
      if (en_cnt == 10 && !i_halt) i_halt = 1'b1;
    end
    check("run_enable_cycles", 32'(en_cnt), 32'd10);
    check("run_end_enable", 32'(o_pipeline_enable), 32'd0);
    check("run_end_busy", 32'(o_busy), 32'd0);
    @(posedge i_clk); #1;

    // RUN and STEP while halted
    send_cmd(C_RUN);
    en_cnt = 0; busy_cnt = 0;
    repeat (5) begin
      @(negedge i_clk);
      en_cnt += int'(o_pipeline_enable);
      busy_cnt += int'(o_busy);
    end
    check("run_halted_enable", 32'(en_cnt), 32'd0);
    check("run_halted_busy", 32'(busy_cnt), 32'd0);
    @(posedge i_clk); #1;
    send_cmd(C_STEP);
    en_cnt = 0;
    repeat (4) begin
      @(negedge i_clk);
      en_cnt += int'(o_pipeline_enable);
    end
    check("step_halted_enable", 32'(en_cnt), 32'd0);
    @(posedge i_clk); #1;
    i_halt = 1'b0;

    // Dump with ready held high: 128 back-to-back bytes
    i_reg_bank_debug = bank1;
    i_tx_ready = 1'b1;
    push_bank(bank1);
    send_cmd(C_DUMP);
    vcnt = 0; done = 1'b0;
    for (int i = 0; i < 300 && !done; i++) begin
      @(negedge i_clk);
      if (o_tx_valid) begin
        vcnt++;
        if (vcnt == 3) begin
          check("dump_ready_low", 32'(o_cmd_ready), 32'd0);
          check("dump_enable_low", 32'(o_pipeline_enable), 32'd0);
        end
      end else if (exp_q.size() == 0) done = 1'b1;
    end
    check("dump1_done", 32'(done), 32'd1);
    check("dump1_valid_cycles", 32'(vcnt), 32'd128);
    check("dump1_valid_end", 32'(o_tx_valid), 32'd0);
    check("dump1_busy_end", 32'(o_busy), 32'd0);
    @(posedge i_clk); #1;

    // Dump with random back-pressure and the bank changing mid-dump
    i_reg_bank_debug = bank2;
    push_bank(bank2);
    send_cmd(C_DUMP);
    done = 1'b0;
    for (int i = 0; i < 2000 && !done; i++) begin
      i_tx_ready = 1'($urandom_range(0, 1));
      if (i == 20) i_reg_bank_debug = ~bank2;
      if (i == 60) i_reg_bank_debug = bank1;
      @(posedge i_clk); #1;
      if (exp_q.size() == 0 && !o_tx_valid) done = 1'b1;
    end
    check("dump2_done", 32'(done), 32'd1);
    check("dump2_busy_end", 32'(o_busy), 32'd0);

    // Reset after 5 bytes, then a fresh dump restarts at register 0 MSB
    i_tx_ready = 1'b1;
    i_reg_bank_debug = bank1;
    base = n_pop;
    push_bank(bank1);
    send_cmd(C_DUMP);
    done = 1'b0;
    for (int i = 0; i < 50 && !done; i++) begin
      @(posedge i_clk); #1;
      if (n_pop - base >= 5) done = 1'b1;
    end
    check("dump3_five_bytes", 32'(n_pop - base), 32'd5);
    i_reset = 1'b0;
    exp_q.delete();
    #1;
    check("mid_rst_valid", 32'(o_tx_valid), 32'd0);
    check("mid_rst_busy", 32'(o_busy), 32'd0);
    check("mid_rst_data", 32'(o_tx_data), 32'd0);
    repeat (2) @(posedge i_clk);
    #1;
    i_reset = 1'b1;
    @(posedge i_clk); #1;
    base = n_pop;
    push_bank(bank1);
    send_cmd(C_DUMP);
    done = 1'b0;
    for (int i = 0; i < 300 && !done; i++) begin
      @(posedge i_clk); #1;
      if (exp_q.size() == 0 && !o_tx_valid) done = 1'b1;
    end
    check("dump4_done", 32'(done), 32'd1);
    check("dump4_bytes", 32'(n_pop - base), 32'd128);
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pipeline_debug_ctrl.md
Name: pipeline_debug_ctrl

Overview:
- Host-facing debug sequencer for the MIPS pipeline.
- Accepts byte commands from the debug link and gates the pipeline clock-enable to run or single-step.
- On request, snapshots the register-bank debug bus from the ID stage and streams it out bytewise over a valid/ready TX interface.
- Sits between the UART RX/TX wrappers and the pipeline top.

Parameters:
- REGISTER_BANK_SIZE, 32, number of registers in the debug bus.
- BUS_SIZE, 32, register width in bits; multiple of 8.
- CMD_RUN, 8'h52, run-until-halt command code.
- CMD_STEP, 8'h53, single-step command code.
- CMD_DUMP, 8'h44, register-dump command code.

Ports:
- i_clk  in  1  clock.
- i_reset  in  1  asynchronous, active-low reset.
- i_cmd  in  8  command byte from RX.
- i_cmd_valid  in  1  command byte valid.
- o_cmd_ready  out  1  controller can accept a command.
- i_halt  in  1  pipeline reached halt instruction (level).
- i_reg_bank_debug  in  REGISTER_BANK_SIZE*BUS_SIZE  flattened register bank; register k at bits [k*BUS_SIZE +: BUS_SIZE].
- o_pipeline_enable  out  1  pipeline advance enable.
- o_tx_data  out  8  byte to TX.
- o_tx_valid  out  1  o_tx_data valid.
- i_tx_ready  in  1  TX accepts byte.
- o_busy  out  1  state != IDLE.

Behaviour:
- Reset (i_reset=0, async): state IDLE, o_pipeline_enable=0, o_tx_valid=0, o_tx_data=0, byte counter=0, snapshot=0. o_cmd_ready=1 only after reset release.
- All outputs are registered, except o_cmd_ready and o_busy, which are decoded from state.
- States: IDLE, RUN, STEP, DUMP.
- o_cmd_ready=1 only in IDLE. A command is accepted when i_cmd_valid && o_cmd_ready, and the decision is taken in the acceptance cycle.
- IDLE + CMD_RUN:
  - If i_halt=0: go to RUN; o_pipeline_enable=1 from the next cycle.
  - If i_halt=1: consumed, stay in IDLE, enable stays 0.
- RUN: o_pipeline_enable=1 every cycle. The first cycle with i_halt=1 sampled causes enable=0 and state IDLE on the next edge. No other exit except reset.
- IDLE + CMD_STEP:
  - If i_halt=0: go to STEP; o_pipeline_enable=1 for exactly one cycle, then 0 and IDLE.
  - If i_halt=1: consumed, no enable pulse.
- IDLE + CMD_DUMP:
  - Capture i_reg_bank_debug into the snapshot in the acceptance cycle.
  - Go to DUMP; byte index = 0.
  - o_tx_valid=1 with the first byte on the next cycle.
- DUMP sequence:
  - Bytes are sent as register 0..REGISTER_BANK_SIZE-1.
  - Within each register, the most significant byte goes first.
  - Total N = REGISTER_BANK_SIZE*BUS_SIZE/8 bytes (128 at default).
- DUMP handshake:
  - o_tx_data is stable while o_tx_valid=1 && i_tx_ready=0.
  - A transfer happens when valid && ready. The next byte is presented in the following cycle with valid held high (no bubble).
  - After the transfer of byte N-1: o_tx_valid=0, state IDLE.
- o_pipeline_enable=0 in DUMP.
- Unknown command codes: consumed in IDLE, no effect.
- i_cmd_valid outside IDLE: not consumed, because ready=0; the sender holds it.
- Snapshot is frozen for the whole dump; changes on i_reg_bank_debug during DUMP are ignored.
- Reset asserted mid-RUN or mid-DUMP: immediate return to the reset values. No partial byte completes; the dump restarts only on a new CMD_DUMP.
- i_halt rising in the same cycle a CMD_RUN is accepted: i_halt is sampled as 1, so the command is ignored.

Test Plan:
- Reset with i_reset=0 for 3 cycles, then release → o_pipeline_enable=0, o_tx_valid=0, o_busy=0, o_cmd_ready=1.
- CMD_STEP (8'h53) with i_halt=0 → o_pipeline_enable high for exactly 1 cycle, o_busy high for 1 cycle, back in IDLE.
- CMD_RUN (8'h52), i_halt raised after 10 cycles → enable high for exactly 10 cycles, then 0. A second CMD_RUN with i_halt=1 produces no enable.
- Load register k = 32'hA0A0_0000 + k, send CMD_DUMP (8'h44) with i_tx_ready=1 → 128 consecutive bytes, first 8'hA0,8'hA0,8'h00,8'h00, last byte 8'h1F, then o_tx_valid=0.
- Dump with i_tx_ready toggling randomly and i_reg_bank_debug changed mid-dump → byte stream identical to the snapshot, with o_tx_data stable during each stall.
- Assert reset after 5 dump bytes → o_tx_valid=0 immediately. A new CMD_DUMP restarts from register 0 MSB.
